// File: rtl/ysyx_040066_mem.sv
// rtl/ysyx_040066_mem.sv - MEM pipeline stage: stage register, load/store bus FSM, lane select and extension
//
// Purpose: captures one EX-stage instruction, performs at most one data-bus
// transaction for it, and presents the writeback result to WB.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   valid_in, block_in         EX instruction valid, WB stall
//   result_in, src2_in         ALU result (address or writeback value), store data
//   MemOp_in, MemRd_in,
//   MemWr_in, RegWr_in,
//   rd_in, pc_in               instruction control and identity
//   mem_req, mem_addr,
//   mem_wen, mem_wdata,
//   mem_wmask                  data-bus request
//   mem_ready, mem_rvalid,
//   mem_rdata                  data-bus accept and read response
//   valid, rd, RegWr, wb_data,
//   pc, misalign               result presented to WB
//   busy                       upstream stall: EX holds while high

module ysyx_040066_mem (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic        block_in,
   input  logic [63:0] result_in,
   input  logic [63:0] src2_in,
   input  logic [2:0]  MemOp_in,
   input  logic        MemRd_in,
   input  logic        MemWr_in,
   input  logic        RegWr_in,
   input  logic [4:0]  rd_in,
   input  logic [63:0] pc_in,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   output logic        mem_wen,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata,
   output logic        valid,
   output logic [4:0]  rd,
   output logic        RegWr,
   output logic [63:0] wb_data,
   output logic [63:0] pc,
   output logic        misalign,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state, state_next;

   logic        valid_native;
   logic [63:0] result_r;
   logic [63:0] src2_r;
   logic [2:0]  memop_r;
   logic        memrd_r;
   logic        memwr_r;
   logic        regwr_r;
   logic [4:0]  rd_r;
   logic [63:0] pc_r;
   logic [63:0] wb_data_r;

   logic        capture;
   logic        mem_op_r;
   logic        mis_r;
   logic [2:0]  addr_lo;
   logic        start_bus;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] word_sel;
   logic [63:0] load_val;

   // Access size comes from the low two MemOp bits; the unsigned variants
   // share the alignment rule of their signed counterparts.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] a);
      case (size)
         2'b00:   return 1'b0;
         2'b01:   return a[0];
         2'b10:   return a[1:0] != 2'b00;
         default: return a != 3'b000;
      endcase
   endfunction

   assign addr_lo  = result_r[2:0];
   assign mem_op_r = memrd_r | memwr_r;
   assign mis_r    = mem_op_r && is_misaligned(memop_r[1:0], addr_lo);

   assign valid    = valid_native && (!mem_op_r || (state == S_DONE) || mis_r);
   assign misalign = valid_native && mis_r;
   assign RegWr    = regwr_r && valid && !misalign;
   assign busy     = valid_native && !(valid && !block_in);
   assign capture  = !busy;

   assign rd       = rd_r;
   assign pc       = pc_r;
   assign wb_data  = wb_data_r;
   assign mem_addr = result_r;

   // Only a valid, aligned memory op starts a bus transaction.
   assign start_bus = valid_in && (MemRd_in || MemWr_in)
                      && !is_misaligned(MemOp_in[1:0], result_in[2:0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         valid_native <= 1'b0;
         result_r     <= 64'd0;
         src2_r       <= 64'd0;
         memop_r      <= 3'd0;
         memrd_r      <= 1'b0;
         memwr_r      <= 1'b0;
         regwr_r      <= 1'b0;
         rd_r         <= 5'd0;
         pc_r         <= 64'd0;
         wb_data_r    <= 64'd0;
      end else begin
         state <= state_next;
         if (capture) begin
            valid_native <= valid_in;
            result_r     <= result_in;
            src2_r       <= src2_in;
            memop_r      <= MemOp_in;
            memrd_r      <= MemRd_in;
            memwr_r      <= MemWr_in;
            regwr_r      <= RegWr_in;
            rd_r         <= rd_in;
            pc_r         <= pc_in;
            // wb_data only moves for real instructions so a bubble after
            // reset leaves it cleared.
            if (valid_in) begin
               wb_data_r <= result_in;
            end
         end else if ((state == S_RESP) && mem_rvalid) begin
            wb_data_r <= load_val;
         end
      end
   end

   always_comb begin
      state_next = state;
      mem_req    = 1'b0;
      mem_wen    = 1'b0;
      case (state)
         S_REQ: begin
            mem_req = 1'b1;
            mem_wen = memwr_r;
            if (mem_ready) begin
               state_next = memwr_r ? S_DONE : S_RESP;
            end
         end
         S_RESP: begin
            if (mem_rvalid) begin
               state_next = S_DONE;
            end
         end
         default: state_next = state;
      endcase
      // A capture can only happen while no transaction is outstanding, so
      // it safely overrides the transaction progress above.
      if (capture) begin
         state_next = start_bus ? S_REQ : S_IDLE;
      end
   end

   // Read lane select and extension.
   always_comb begin
      byte_sel = mem_rdata[{addr_lo, 3'b000} +: 8];
      half_sel = mem_rdata[{addr_lo[2:1], 4'b0000} +: 16];
      word_sel = mem_rdata[{addr_lo[2], 5'b00000} +: 32];
      case (memop_r)
         3'b000:  load_val = {{56{byte_sel[7]}}, byte_sel};
         3'b001:  load_val = {{48{half_sel[15]}}, half_sel};
         3'b010:  load_val = {{32{word_sel[31]}}, word_sel};
         3'b100:  load_val = {56'd0, byte_sel};
         3'b101:  load_val = {48'd0, half_sel};
         3'b110:  load_val = {32'd0, word_sel};
         default: load_val = mem_rdata;
      endcase
   end

   // Store data is replicated across every lane; the mask picks the lane.
   always_comb begin
      case (memop_r[1:0])
         2'b00: begin
            mem_wdata = {8{src2_r[7:0]}};
            mem_wmask = 8'h01 << addr_lo;
         end
         2'b01: begin
            mem_wdata = {4{src2_r[15:0]}};
            mem_wmask = 8'h03 << {addr_lo[2:1], 1'b0};
         end
         2'b10: begin
            mem_wdata = {2{src2_r[31:0]}};
            mem_wmask = 8'h0f << {addr_lo[2], 2'b00};
         end
         default: begin
            mem_wdata = src2_r;
            mem_wmask = 8'hff;
         end
      endcase
   end

endmodule

// File: tb/tb_ysyx_040066_mem.sv
// tb/tb_ysyx_040066_mem.sv - self-checking bench for ysyx_040066_mem
module tb_ysyx_040066_mem;

   logic        clk = 1'b0;
   logic        rst, valid_in, block_in;
   logic [63:0] result_in, src2_in, pc_in;
   logic [2:0]  MemOp_in;
   logic        MemRd_in, MemWr_in, RegWr_in;
   logic [4:0]  rd_in;
   logic        mem_req, mem_wen, mem_ready, mem_rvalid;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;
   logic        valid, RegWr, misalign, busy;
   logic [4:0]  rd;
   logic [63:0] wb_data, pc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_040066_mem dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .block_in(block_in),
      .result_in(result_in), .src2_in(src2_in), .MemOp_in(MemOp_in),
      .MemRd_in(MemRd_in), .MemWr_in(MemWr_in), .RegWr_in(RegWr_in),
      .rd_in(rd_in), .pc_in(pc_in),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .valid(valid), .rd(rd), .RegWr(RegWr), .wb_data(wb_data), .pc(pc),
      .misalign(misalign), .busy(busy)
   );

   // Reference model: access size in bytes from MemOp.
   function automatic int size_of(input logic [2:0] op);
      case (op)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         3'd2, 3'd6: return 4;
         default:    return 8;
      endcase
   endfunction

   function automatic logic exp_mis(input logic [2:0] op, input logic [2:0] a);
      return (int'(a) % size_of(op)) != 0;
   endfunction

   function automatic logic [63:0] exp_load(input logic [2:0] op, input logic [2:0] a, input logic [63:0] data);
      int n;
      logic [63:0] v, m;
      n = size_of(op);
      v = data >> (8 * int'(a));
      if (n < 8) begin
         m = (64'd1 << (8 * n)) - 64'd1;
         v = v & m;
         if (op < 3'd3 && v[8 * n - 1]) v = v | ~m;
      end
      return v;
   endfunction

   function automatic logic [63:0] exp_wdata(input logic [2:0] op, input logic [63:0] s2);
      int n;
      logic [63:0] v, m;
      n = size_of(op);
      m = (n == 8) ? {64{1'b1}} : ((64'd1 << (8 * n)) - 64'd1);
      v = 64'd0;
      for (int i = 0; i < 8 / n; i++) v = v | ((s2 & m) << (8 * n * i));
      return v;
   endfunction

   function automatic logic [7:0] exp_wmask(input logic [2:0] op, input logic [2:0] a);
      logic [15:0] t;
      t = ((16'd1 << size_of(op)) - 16'd1) << a;
      return t[7:0];
   endfunction

   task automatic drive(input logic v, input logic [2:0] op, input logic rdf, input logic wrf,
                        input logic rw, input logic [63:0] res, input logic [63:0] s2,
                        input logic [4:0] rdn, input logic [63:0] pcv);
      valid_in = v; MemOp_in = op; MemRd_in = rdf; MemWr_in = wrf; RegWr_in = rw;
      result_in = res; src2_in = s2; rd_in = rdn; pc_in = pcv;
   endtask

   task automatic do_reset();
      rst = 1'b1; valid_in = 1'b0; block_in = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      drive(0, 3'd0, 0, 0, 0, 64'd0, 64'd0, 5'd0, 64'd0);
      mem_rdata = 64'd0;
      do_reset();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
      checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL reset_regwr got %b exp 0", RegWr); end
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
      checks++; if (wb_data !== 64'd0) begin errors++; $display("FAIL reset_wb_data got %h exp 0", wb_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
   endtask

   task automatic test_alu();
      logic [63:0] res;
      logic rw;
      do_reset();
      drive(1, 3'd0, 0, 0, 1, 64'h1234, 64'd0, 5'd3, 64'h8000_0000);
      @(negedge clk);
      valid_in = 1'b0;
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL alu_valid got %b exp 1", valid); end
      checks++; if (wb_data !== 64'h1234) begin errors++; $display("FAIL alu_wb_data got %h exp 1234", wb_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL alu_busy got %b exp 0", busy); end
      checks++; if (RegWr !== 1'b1) begin errors++; $display("FAIL alu_regwr got %b exp 1", RegWr); end
      for (int i = 0; i < 6; i++) begin
         res = {$urandom, $urandom};
         rw = 1'($urandom_range(0, 1));
         drive(1, 3'($urandom_range(0, 6)), 0, 0, rw, res, {$urandom, $urandom}, 5'(i), 64'(i));
         @(negedge clk);
         for (int b = 0; b < 2; b++) begin
            block_in = 1'b1; valid_in = 1'b1; result_in = {$urandom, $urandom};
            #1;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL alu_block_busy got %b exp 1", busy); end
            @(negedge clk);
            checks++; if (wb_data !== res) begin errors++; $display("FAIL alu_hold_wb got %h exp %h", wb_data, res); end
            checks++; if (RegWr !== rw) begin errors++; $display("FAIL alu_hold_regwr got %b exp %b", RegWr, rw); end
         end
         block_in = 1'b0; valid_in = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic test_load_byte();
      logic [2:0]  ops  [2] = '{3'b000, 3'b100};
      logic [63:0] exps [2] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080};
      do_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1, ops[i], 1, 0, 1, 64'h8000_1003, 64'd0, 5'd9, 64'h100);
         @(negedge clk);
         valid_in = 1'b0;
         checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h8000_1003 || mem_wen !== 1'b0) begin errors++; $display("FAIL lb_req got req=%b addr=%h wen=%b exp 1 80001003 0", mem_req, mem_addr, mem_wen); end
         checks++; if (valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL lb_req_valid got valid=%b busy=%b exp 0 1", valid, busy); end
         mem_ready = 1'b1;
         @(negedge clk);
         mem_ready = 1'b0;
         checks++; if (mem_req !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL lb_resp got req=%b valid=%b exp 0 0", mem_req, valid); end
         mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_80FF_0000;
         @(negedge clk);
         mem_rvalid = 1'b0; mem_rdata = 64'h0;
         checks++; if (valid !== 1'b1 || RegWr !== 1'b1) begin errors++; $display("FAIL lb_done got valid=%b regwr=%b exp 1 1", valid, RegWr); end
         checks++; if (wb_data !== exps[i]) begin errors++; $display("FAIL lb_data got %h exp %h", wb_data, exps[i]); end
      end
   endtask

   task automatic test_store_half();
      do_reset();
      drive(1, 3'b001, 0, 1, 0, 64'h8000_0006, 64'hABCD, 5'd0, 64'h200);
      @(negedge clk);
      valid_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++; if (mem_req !== 1'b1 || mem_wen !== 1'b1) begin errors++; $display("FAIL sh_req got req=%b wen=%b exp 1 1", mem_req, mem_wen); end
         checks++; if (mem_wmask !== 8'hC0) begin errors++; $display("FAIL sh_wmask got %h exp c0", mem_wmask); end
         checks++; if (mem_wdata !== 64'hABCD_ABCD_ABCD_ABCD) begin errors++; $display("FAIL sh_wdata got %h exp abcdabcdabcdabcd", mem_wdata); end
         mem_ready = (k == 2);
         @(negedge clk);
      end
      mem_ready = 1'b0;
      checks++; if (valid !== 1'b1 || mem_req !== 1'b0 || mem_wen !== 1'b0 || RegWr !== 1'b0) begin errors++; $display("FAIL sh_done got valid=%b req=%b wen=%b regwr=%b exp 1 0 0 0", valid, mem_req, mem_wen, RegWr); end
   endtask

   task automatic test_misalign();
      logic [2:0] ops [4] = '{3'b010, 3'b001, 3'b011, 3'b101};
      logic [2:0] ad  [4] = '{3'd2, 3'd1, 3'd4, 3'd3};
      do_reset();
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1, ops[i], 1, 0, 1, {61'h100, ad[i]}, 64'd0, 5'd1, 64'h300);
         @(negedge clk);
         valid_in = 1'b0;
         checks++; if (misalign !== 1'b1 || valid !== 1'b1) begin errors++; $display("FAIL mis_flag got mis=%b valid=%b exp 1 1", misalign, valid); end
         checks++; if (RegWr !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL mis_req got regwr=%b req=%b exp 0 0", RegWr, mem_req); end
      end
      @(negedge clk);
      checks++; if (mem_req !== 1'b0 || misalign !== 1'b0) begin errors++; $display("FAIL mis_after got req=%b mis=%b exp 0 0", mem_req, misalign); end
      mem_ready = 1'b0;
   endtask

   task automatic test_delayed_ld();
      logic [63:0] data;
      data = {$urandom, $urandom};
      do_reset();
      drive(1, 3'b011, 1, 0, 1, 64'h8000_2008, 64'd0, 5'd4, 64'h400);
      @(negedge clk);
      valid_in = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h8000_2008) begin errors++; $display("FAIL ld_wait_req got req=%b addr=%h exp 1 80002008", mem_req, mem_addr); end
         checks++; if (busy !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL ld_wait_busy got busy=%b valid=%b exp 1 0", busy, valid); end
         mem_ready = (k == 4);
         @(negedge clk);
      end
      mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++; if (busy !== 1'b1 || valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL ld_resp got busy=%b valid=%b req=%b exp 1 0 0", busy, valid, mem_req); end
         mem_rvalid = (k == 2); mem_rdata = data;
         @(negedge clk);
      end
      mem_rvalid = 1'b0;
      checks++; if (valid !== 1'b1 || wb_data !== data) begin errors++; $display("FAIL ld_done got valid=%b data=%h exp 1 %h", valid, wb_data, data); end
   endtask

   task automatic test_reset_resp();
      do_reset();
      drive(1, 3'b011, 1, 0, 1, 64'h2000, 64'd0, 5'd7, 64'h500);
      @(negedge clk);
      valid_in = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      checks++; if (mem_req !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rr_in_resp got req=%b busy=%b exp 0 1", mem_req, busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
      @(negedge clk);
      mem_rvalid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++; if (valid !== 1'b0 || wb_data !== 64'd0) begin errors++; $display("FAIL rr_state got valid=%b data=%h exp 0 0", valid, wb_data); end
         checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || RegWr !== 1'b0) begin errors++; $display("FAIL rr_ctl got req=%b busy=%b regwr=%b exp 0 0 0", mem_req, busy, RegWr); end
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      int kind, n, a, dr, dv, nb;
      logic [2:0]  op;
      logic [63:0] addr, s2, pcv, rdat, exp_wb;
      logic [4:0]  rdn;
      logic        rw, mis, have_wb;
      do_reset();
      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 2);
         op   = (kind == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
         n    = size_of(op);
         addr = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) begin
            a = int'(addr[2:0]);
            addr[2:0] = 3'(a - (a % n));
         end
         s2 = {$urandom, $urandom}; pcv = {$urandom, $urandom};
         rdn = 5'($urandom_range(0, 31)); rw = 1'($urandom_range(0, 1));
         mis = (kind != 0) && exp_mis(op, addr[2:0]);
         have_wb = (kind == 0);
         exp_wb = addr;
         drive(1, op, kind == 1, kind == 2, rw, addr, s2, rdn, pcv);
         @(negedge clk);
         valid_in = 1'b0; result_in = {$urandom, $urandom}; src2_in = {$urandom, $urandom};
         MemOp_in = 3'($urandom_range(0, 7)); pc_in = {$urandom, $urandom};
         if (kind == 0 || mis) begin
            checks++; if (valid !== 1'b1 || misalign !== mis || mem_req !== 1'b0) begin errors++; $display("FAIL rnd_fast got valid=%b mis=%b req=%b exp 1 %b 0", valid, misalign, mem_req, mis); end
            checks++; if (RegWr !== (rw && !mis)) begin errors++; $display("FAIL rnd_fast_regwr got %b exp %b", RegWr, rw && !mis); end
            if (kind == 0) begin
               checks++; if (wb_data !== addr) begin errors++; $display("FAIL rnd_alu_wb got %h exp %h", wb_data, addr); end
            end
         end else begin
            dr = $urandom_range(0, 3);
            for (int k = 0; k <= dr; k++) begin
               checks++; if (mem_req !== 1'b1 || mem_addr !== addr || mem_wen !== (kind == 2) || valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rnd_req got req=%b addr=%h wen=%b valid=%b busy=%b exp addr %h", mem_req, mem_addr, mem_wen, valid, busy, addr); end
               if (kind == 2) begin
                  checks++; if (mem_wdata !== exp_wdata(op, s2) || mem_wmask !== exp_wmask(op, addr[2:0])) begin errors++; $display("FAIL rnd_store got data=%h mask=%h exp %h %h", mem_wdata, mem_wmask, exp_wdata(op, s2), exp_wmask(op, addr[2:0])); end
               end
               mem_ready = (k == dr);
               mem_rvalid = (k != dr) ? 1'($urandom_range(0, 1)) : 1'b0;
               mem_rdata = {$urandom, $urandom};
               @(negedge clk);
            end
            mem_ready = 1'b0;
            if (kind == 1) begin
               dv = $urandom_range(0, 3);
               rdat = 64'd0;
               for (int k = 0; k <= dv; k++) begin
                  checks++; if (mem_req !== 1'b0 || valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rnd_resp got req=%b valid=%b busy=%b exp 0 0 1", mem_req, valid, busy); end
                  mem_ready = 1'($urandom_range(0, 1));
                  mem_rvalid = (k == dv);
                  rdat = {$urandom, $urandom};
                  mem_rdata = rdat;
                  @(negedge clk);
               end
               mem_rvalid = 1'b0; mem_ready = 1'b0;
               have_wb = 1'b1;
               exp_wb = exp_load(op, addr[2:0], rdat);
               checks++; if (wb_data !== exp_wb) begin errors++; $display("FAIL rnd_load got %h exp %h op %0d a %0d", wb_data, exp_wb, op, addr[2:0]); end
            end
            checks++; if (valid !== 1'b1 || misalign !== 1'b0 || mem_req !== 1'b0 || RegWr !== rw) begin errors++; $display("FAIL rnd_done got valid=%b mis=%b req=%b regwr=%b exp 1 0 0 %b", valid, misalign, mem_req, RegWr, rw); end
         end
         checks++; if (rd !== rdn || pc !== pcv) begin errors++; $display("FAIL rnd_id got rd=%0d pc=%h exp %0d %h", rd, pc, rdn, pcv); end
         nb = $urandom_range(0, 2);
         for (int b = 0; b < nb; b++) begin
            block_in = 1'b1; valid_in = 1'b1;
            mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = {$urandom, $urandom};
            #1;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rnd_block_busy got %b exp 1", busy); end
            @(negedge clk);
            checks++; if (valid !== 1'b1 || (have_wb && wb_data !== exp_wb)) begin errors++; $display("FAIL rnd_block_hold got valid=%b data=%h exp 1 %h", valid, wb_data, exp_wb); end
         end
         block_in = 1'b0; valid_in = 1'b0; mem_rvalid = 1'b0;
         #1;
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_release_busy got %b exp 0", busy); end
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_alu();
      test_load_byte();
      test_store_half();
      test_misalign();
      test_delayed_ld();
      test_reset_resp();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
